s3g_packet_rx: RTL

- Byte-level S3G packet receiver that sits directly downstream of the UART transceiver's receive side and directly upstream of the S3G command executor.
- Hunts for the 0xD5 start byte, captures the length and payload into an internal buffer, and checks the iButton CRC-8.
- Presents a completed packet through a hold/ack handshake with a random-access read port.
- Reports framing errors using S3G response codes, so the executor and TX path can forward them unchanged.

---
 rtl/s3g_packet_rx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/s3g_packet_rx.sv
// S3G packet receiver: start-byte hunt, length/payload capture, iButton CRC-8 check, hold/ack read port.
// Optional statistics counters are compiled in with `define S3G_PACKET_RX_STATS_EN.
module s3g_packet_rx #(
  parameter int MAX_LEN        = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              pkt_valid,
  output logic [7:0]        pkt_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              pkt_ack,
  output logic              err_valid,
  output logic [7:0]        err_code,
  output logic              busy,
  output logic [7:0]        crc
`ifdef S3G_PACKET_RX_STATS_EN
  ,
  output logic [15:0]       stat_good,
  output logic [15:0]       stat_crc_err,
  output logic [15:0]       stat_timeout
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] START_BYTE  = 8'hD5;
  localparam logic [7:0] ERR_GENERIC = 8'h80;
  localparam logic [7:0] ERR_BUSY    = 8'h82;
  localparam logic [7:0] ERR_CRC     = 8'h83;
  localparam logic [7:0] ERR_TOO_BIG = 8'h84;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_HOLD
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      len_q;
  logic [7:0]      idx;
  logic [7:0]      buf_mem [2**ADDR_W];

  logic            mid_pkt;
  logic            timeout_hit;
  logic [7:0]      crc_next;
  logic            err_evt;
  logic [7:0]      err_evt_code;
  logic            crc_match;

  // Dallas/iButton CRC-8, reflected poly 0x8C, one bit per iteration LSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       mix;
    r = c;
    for (int i = 0; i < 8; i++) begin
      mix = r[0] ^ d[i];
      r   = {1'b0, r[7:1]};
      if (mix) r = r ^ 8'h8C;
    end
    return r;
  endfunction

  assign crc_next    = crc8_step(crc, rx_data);
  assign mid_pkt     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CRC);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = mid_pkt && !rx_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign crc_match   = (rx_data == crc);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    err_evt      = 1'b0;
    err_evt_code = ERR_GENERIC;
    case (state)
      ST_LEN: begin
        if (rx_done && rx_data == 8'd0) begin
          err_evt = 1'b1; err_evt_code = ERR_GENERIC;
        end else if (rx_done && rx_data > 8'(MAX_LEN)) begin
          err_evt = 1'b1; err_evt_code = ERR_TOO_BIG;
        end else if (timeout_hit) begin
          err_evt = 1'b1; err_evt_code = ERR_GENERIC;
        end
      end
      ST_PAYLOAD: begin
        if (timeout_hit) begin
          err_evt = 1'b1; err_evt_code = ERR_GENERIC;
        end
      end
      ST_CRC: begin
        if (rx_done && !crc_match) begin
          err_evt = 1'b1; err_evt_code = ERR_CRC;
        end else if (timeout_hit) begin
          err_evt = 1'b1; err_evt_code = ERR_GENERIC;
        end
      end
      ST_HOLD: begin
        if (rx_done) begin
          err_evt = 1'b1; err_evt_code = ERR_BUSY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      len_q     <= 8'd0;
      idx       <= 8'd0;
      pkt_valid <= 1'b0;
      pkt_len   <= 8'd0;
      err_valid <= 1'b0;
      err_code  <= 8'd0;
      crc       <= 8'd0;
      rd_data   <= 8'd0;
    end else begin
      err_valid <= err_evt;
      if (err_evt) err_code <= err_evt_code;
      rd_data <= buf_mem[rd_addr];

      if (!mid_pkt || rx_done || timeout_hit) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + TW'(1);

      case (state)
        ST_IDLE: begin
          if (rx_done && rx_data == START_BYTE) begin
            state <= ST_LEN;
            crc   <= 8'd0;
          end
        end
        ST_LEN: begin
          if (rx_done) begin
            if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
              state <= ST_IDLE;
            end else begin
              len_q <= rx_data;
              idx   <= 8'd0;
              state <= ST_PAYLOAD;
            end
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (rx_done) begin
            crc <= crc_next;
            idx <= idx + 8'd1;
            if ((idx + 8'd1) == len_q) state <= ST_CRC;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_CRC: begin
          if (rx_done) begin
            if (crc_match) begin
              state     <= ST_HOLD;
              pkt_valid <= 1'b1;
              pkt_len   <= len_q;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (pkt_ack) begin
            pkt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Buffer has no reset; it is only written while collecting payload, so it stays frozen in HOLD.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_PAYLOAD && rx_done) buf_mem[idx[ADDR_W-1:0]] <= rx_data;
  end

`ifdef S3G_PACKET_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good    <= 16'd0;
      stat_crc_err <= 16'd0;
      stat_timeout <= 16'd0;
    end else begin
      if (state == ST_CRC && rx_done && crc_match && stat_good != 16'hFFFF)
        stat_good <= stat_good + 16'd1;
      if (err_evt && err_evt_code == ERR_CRC && stat_crc_err != 16'hFFFF)
        stat_crc_err <= stat_crc_err + 16'd1;
      if (timeout_hit && stat_timeout != 16'hFFFF)
        stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif

endmodule
